tdm_demux8: RTL and testbench
=============================

TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port din, input, 1 bit: serial TDM data, one channel bit per valid cycle.
REQ-004 SHALL have port din_valid, input, 1 bit: qualifies din and sync; when low, the cycle is ignored.
REQ-005 SHALL have port sync, input, 1 bit: frame marker, high with the channel-0 bit of each frame.
REQ-006 SHALL have port q, output, 8 bits: parallel channels; q[i] = channel i of the last complete frame.
REQ-007 SHALL have port frame_done, output, 1 bit: one-cycle pulse, high in the cycle q is updated.
REQ-008 SHALL have port sel, output, 3 bits: index of the channel expected on the next valid bit.
REQ-009 SHALL have port locked, output, 1 bit: high while in state RECV.
REQ-010 SHALL have port sync_err, output, 1 bit: one-cycle pulse on a framing error.

Function
REQ-011 SHALL implement two states, HUNT and RECV, plus a 3-bit channel counter cnt and an 8-bit holding register hold.
REQ-012 SHALL drive sel from cnt and locked from (state==RECV); all outputs SHALL be registered.
REQ-013 A cycle with din_valid=0 SHALL leave cnt, hold, state and q unchanged, with frame_done=0 and sync_err=0.
REQ-014 HUNT, valid, sync=0: din SHALL be discarded and the block SHALL stay in HUNT.
REQ-015 HUNT, valid, sync=1: hold[0]<=din, cnt<=1, next state RECV.
REQ-016 RECV, valid, cnt==0, sync=1: hold[0]<=din, cnt<=1 (normal frame start).
REQ-017 RECV, valid, 1<=cnt<=6, sync=0: hold[cnt]<=din, cnt<=cnt+1.
REQ-018 RECV, valid, cnt==7, sync=0:
- q<={din, hold[6:0]}, frame_done=1, cnt<=0 (wrap), stay in RECV.
- Latency: q and frame_done SHALL be visible the cycle after the edge that samples channel 7.
REQ-019 RECV, valid, cnt!=0, sync=1 (early sync):
- sync_err=1 for one cycle.
- Partial frame discarded; q unchanged.
- din taken as channel 0: hold[0]<=din, cnt<=1, stay in RECV.
REQ-020 RECV, valid, cnt==0, sync=0 (missing sync):
- sync_err=1 for one cycle; din discarded.
- cnt<=0, next state HUNT; q unchanged.
REQ-021 frame_done and sync_err SHALL never be high in the same cycle, and neither SHALL stay high for more than one cycle per triggering event.
REQ-022 Back-to-back frames with din_valid held continuously high SHALL produce frame_done exactly every 8 cycles, with no lost bits.
REQ-023 Unused hold bits from an aborted frame SHALL never reach q.

Reset
REQ-024 When rst=1, without waiting for a clock edge:
- q=8'h00, hold=8'h00, cnt=0, sel=0.
- state=HUNT, locked=0, frame_done=0, sync_err=0.
REQ-025 rst asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait in HUNT for sync.
REQ-026 The first clock edge after rst deasserts SHALL be treated as a normal cycle per REQ-013 to REQ-020.

Verification
REQ-027 Basic frame:
- Stimulus: after reset, valid continuous; ch0..ch7 = 1,0,1,1,0,0,1,0; sync with ch0 only.
- Response: q=8'h4D one cycle after the ch7 edge; frame_done one pulse; locked=1 from the cycle after ch0.
REQ-028 Gapped frame:
- Stimulus: same frame with din_valid low for 3 cycles between ch3 and ch4.
- Response: q=8'h4D; a single frame_done pulse; sel holds 4 during the gap.
REQ-029 Early sync:
- Stimulus: q=8'h4D; next frame has sync at ch5.
- Response: sync_err pulse; q stays 8'h4D; next 8 valid bits 0xFF-pattern (all 1s, sync on the first) give q=8'hFF.
REQ-030 Missing sync:
- Stimulus: second frame sent with sync=0 on ch0.
- Response: sync_err pulse; locked=0; following bits ignored until sync; q unchanged.
REQ-031 Asynchronous reset:
- Stimulus: rst raised between clock edges at cnt=4.
- Response: q=0, sel=0, locked=0 immediately; a full frame after release decodes correctly.
REQ-032 Back-to-back frames:
- Stimulus: 4 consecutive frames, continuous valid, values 8'h01, 8'h80, 8'hA5, 8'h5A.
- Response: frame_done every 8 cycles; q steps through those values in order.

Source files
------------

// File: rtl/tdm_demux8.sv
// tdm_demux8: 8-channel serial TDM demultiplexer with sync-based framing.
// A frame is 8 qualified bits, channel 0 first, with sync high on channel 0.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   din        - serial data, one channel bit per valid cycle
//   din_valid  - qualifies din and sync
//   sync       - frame marker, high with the channel-0 bit
//   q          - channels of the last complete frame (q[i] = channel i)
//   frame_done - one-cycle pulse when q is updated
//   sel        - channel index expected on the next valid bit
//   locked     - high while receiving framed data
//   sync_err   - one-cycle pulse on early or missing sync
module tdm_demux8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       din_valid,
   input  logic       sync,
   output logic [7:0] q,
   output logic       frame_done,
   output logic [2:0] sel,
   output logic       locked,
   output logic       sync_err
);

   localparam int unsigned CH_W  = 3;
   localparam int unsigned NCH   = 8;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

   typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

   state_t          state, state_n;
   logic [CH_W-1:0] cnt, cnt_n;
   logic [NCH-1:0]  hold, hold_n;
   logic [NCH-1:0]  q_n;
   logic            frame_done_n;
   logic            sync_err_n;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         cnt        <= '0;
         hold       <= '0;
         q          <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         hold       <= hold_n;
         q          <= q_n;
         frame_done <= frame_done_n;
         sync_err   <= sync_err_n;
      end
   end

   // Next-state and framing decisions
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      hold_n       = hold;
      q_n          = q;
      frame_done_n = 1'b0;
      sync_err_n   = 1'b0;

      if (din_valid) begin
         unique case (state)
            HUNT: begin
               if (sync) begin
                  hold_n[0] = din;
                  cnt_n     = CH_W'(1);
                  state_n   = RECV;
               end
            end
            RECV: begin
               if (sync) begin
                  // Sync restarts the frame; mid-frame it also flags an error
                  sync_err_n = (cnt != '0);
                  hold_n[0]  = din;
                  cnt_n      = CH_W'(1);
               end else if (cnt == '0) begin
                  // Missing sync: drop lock and hunt again
                  sync_err_n = 1'b1;
                  state_n    = HUNT;
               end else if (cnt == LAST_CH) begin
                  // Last channel goes straight to q; stale hold bits cannot leak
                  // because every channel 1..6 was written during this frame
                  q_n          = {din, hold[NCH-2:0]};
                  frame_done_n = 1'b1;
                  cnt_n        = '0;
               end else begin
                  hold_n[cnt] = din;
                  cnt_n       = CH_W'(cnt + CH_W'(1));
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   assign sel    = cnt;
   assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed scenarios plus random traffic,
// compared against a frame-level reference model built on a bit counter.
module tb_tdm_demux8;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       din_valid;
   logic       sync;
   logic [7:0] q;
   logic       frame_done;
   logic [2:0] sel;
   logic       locked;
   logic       sync_err;

   int tests  = 0;
   int failed = 0;

   // Reference model state
   logic [7:0] m_q;
   logic [7:0] m_bits;
   int         m_n;
   bit         m_locked;
   bit         m_done;
   bit         m_err;

   tdm_demux8 dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .q          (q),
      .frame_done (frame_done),
      .sel        (sel),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q = 8'h00; m_bits = 8'h00; m_n = 0;
      m_locked = 0; m_done = 0; m_err = 0;
   endtask

   // Frame-level behaviour: collect bits after a sync until eight are in
   task automatic model_step(input bit d, input bit v, input bit s);
      m_done = 0;
      m_err  = 0;
      if (!v) return;
      if (s) begin
         if (m_locked && m_n != 0) m_err = 1;
         m_bits    = 8'h00;
         m_bits[0] = d;
         m_n       = 1;
         m_locked  = 1;
      end else if (m_locked) begin
         if (m_n == 0) begin
            m_err    = 1;
            m_locked = 0;
         end else begin
            m_bits[m_n] = d;
            m_n++;
            if (m_n == 8) begin
               m_q    = m_bits;
               m_done = 1;
               m_n    = 0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".q"},     q,                     m_q);
      check({tag, ".done"},  8'(frame_done),        8'(m_done));
      check({tag, ".err"},   8'(sync_err),          8'(m_err));
      check({tag, ".sel"},   8'(sel),               8'(m_n));
      check({tag, ".lock"},  8'(locked),            8'(m_locked));
      check({tag, ".excl"},  8'(frame_done & sync_err), 8'h00);
   endtask

   task automatic step(input bit d, input bit v, input bit s, input string tag);
      din = d; din_valid = v; sync = s;
      @(posedge clk);
      #1;
      model_step(d, v, s);
      check_all(tag);
   endtask

   task automatic send_frame(input logic [7:0] val, input string tag);
      for (int i = 0; i < 8; i++) step(val[i], 1'b1, i == 0, tag);
   endtask

   initial begin
      model_reset();
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
      #2;
      check("rst.q", q, 8'h00);
      check("rst.sel", 8'(sel), 8'h00);
      check("rst.lock", 8'(locked), 8'h00);
      check("rst.pulses", 8'({frame_done, sync_err}), 8'h00);
      #10 rst = 1'b0;

      // Basic frame: ch0..ch7 = 1,0,1,1,0,0,1,0 -> 8'h4D
      step(1'b1, 1'b1, 1'b1, "basic0");
      check("basic.locked_after_ch0", 8'(locked), 8'h01);
      for (int i = 1; i < 8; i++) begin
         logic [7:0] v = 8'h4D;
         step(v[i], 1'b1, 1'b0, "basic");
      end
      check("basic.q", q, 8'h4D);
      check("basic.done", 8'(frame_done), 8'h01);
      step(1'b0, 1'b0, 1'b0, "basic.idle");
      check("basic.done_one_pulse", 8'(frame_done), 8'h00);

      // Gapped frame: valid low three cycles between ch3 and ch4
      begin
         logic [7:0] v = 8'h4D;
         for (int i = 0; i < 4; i++) step(v[i], 1'b1, i == 0, "gap.a");
         for (int g = 0; g < 3; g++) begin
            step($urandom_range(0, 1), 1'b0, $urandom_range(0, 1), "gap.idle");
            check("gap.sel_hold", 8'(sel), 8'h04);
         end
         for (int i = 4; i < 8; i++) step(v[i], 1'b1, 1'b0, "gap.b");
         check("gap.q", q, 8'h4D);
      end

      // Early sync at ch5, then an all-ones frame starting on that sync
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i == 0, "early.a");
      step(1'b1, 1'b1, 1'b1, "early.sync");
      check("early.err", 8'(sync_err), 8'h01);
      check("early.q_kept", q, 8'h4D);
      for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b0, "early.b");
      check("early.q_ff", q, 8'hFF);

      // Missing sync on ch0 of the next frame
      step(1'b0, 1'b1, 1'b0, "miss.ch0");
      check("miss.err", 8'(sync_err), 8'h01);
      check("miss.unlocked", 8'(locked), 8'h00);
      for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b0, "miss.ignored");
      check("miss.q_kept", q, 8'hFF);

      // Async reset mid-frame at cnt=4
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, "arst.a");
      check("arst.sel4", 8'(sel), 8'h04);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("arst.q", q, 8'h00);
      check("arst.sel", 8'(sel), 8'h00);
      check("arst.lock", 8'(locked), 8'h00);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b1, 1'b0, "arst.hunt");
      send_frame(8'h3C, "arst.frame");
      check("arst.q_after", q, 8'h3C);

      // Back-to-back frames with continuous valid
      send_frame(8'h01, "b2b");
      check("b2b.q01", q, 8'h01);
      send_frame(8'h80, "b2b");
      check("b2b.q80", q, 8'h80);
      send_frame(8'hA5, "b2b");
      check("b2b.qA5", q, 8'hA5);
      send_frame(8'h5A, "b2b");
      check("b2b.q5A", q, 8'h5A);

      // Random traffic: mostly well-formed frames with noise and gaps
      for (int n = 0; n < 60; n++) begin
         logic [7:0] v = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            while ($urandom_range(0, 3) == 0)
               step($urandom_range(0, 1), 1'b0, $urandom_range(0, 1), "rnd.gap");
            step(v[i], 1'b1, (i == 0) ^ ($urandom_range(0, 15) == 0), "rnd");
         end
      end
      for (int n = 0; n < 300; n++)
         step($urandom_range(0, 1), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0, "rnd.raw");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
